// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back path has priority.
// A one-entry buffer holds multi-cycle results, and a one-cycle forced grant prevents the buffer from starving.
module wb_port_arbiter #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_waddr,
    input  logic [DATA_W-1:0] mc_wdata,
    output logic              mc_ready,
    output logic              pipe_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mc_drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(STARVE_LIMIT - 1);

    state_t            state_r;
    logic              buf_valid_r;
    logic [ADDR_W-1:0] buf_waddr_r;
    logic [DATA_W-1:0] buf_wdata_r;
    logic [3:0]        wait_cnt_r;

    logic              grant_s;
    logic [ADDR_W-1:0] gnt_addr_s;
    logic [DATA_W-1:0] gnt_data_s;

    assign mc_ready = (state_r == IDLE) && !reset;

    // Select the write that owns the register-file port this cycle.
    always_comb begin
        grant_s    = 1'b0;
        gnt_addr_s = {ADDR_W{1'b0}};
        gnt_data_s = {DATA_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (pipe_we) begin
                    grant_s    = 1'b1;
                    gnt_addr_s = pipe_waddr;
                    gnt_data_s = pipe_wdata;
                end else begin
                    grant_s = 1'b0;
                end
            end
            HELD: begin
                if (pipe_we) begin
                    grant_s    = 1'b1;
                    gnt_addr_s = pipe_waddr;
                    gnt_data_s = pipe_wdata;
                end else if (buf_valid_r) begin
                    grant_s    = 1'b1;
                    gnt_addr_s = buf_waddr_r;
                    gnt_data_s = buf_wdata_r;
                end else begin
                    grant_s = 1'b0;
                end
            end
            FORCE: begin
                grant_s    = 1'b1;
                gnt_addr_s = buf_waddr_r;
                gnt_data_s = buf_wdata_r;
            end
            default: begin
                grant_s = 1'b0;
            end
        endcase
    end

    // Arbiter FSM, holding buffer and registered register-file outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            buf_valid_r <= 1'b0;
            buf_waddr_r <= {ADDR_W{1'b0}};
            buf_wdata_r <= {DATA_W{1'b0}};
            wait_cnt_r  <= 4'd0;
            rf_we       <= 1'b0;
            rf_waddr    <= {ADDR_W{1'b0}};
            rf_wdata    <= {DATA_W{1'b0}};
            pipe_stall  <= 1'b0;
            mc_drop     <= 1'b0;
        end else begin
            mc_drop <= 1'b0;
            // r0 is hardwired, so a grant to it completes without a write strobe.
            rf_we   <= grant_s && (gnt_addr_s != {ADDR_W{1'b0}});
            if (grant_s) begin
                rf_waddr <= gnt_addr_s;
                rf_wdata <= gnt_data_s;
            end
            case (state_r)
                IDLE: begin
                    if (mc_valid) begin
                        buf_valid_r <= 1'b1;
                        buf_waddr_r <= mc_waddr;
                        buf_wdata_r <= mc_wdata;
                        wait_cnt_r  <= 4'd0;
                        state_r     <= HELD;
                    end
                end
                HELD: begin
                    if (!pipe_we) begin
                        buf_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else if (pipe_waddr == buf_waddr_r) begin
                        // The newer pipeline value makes the buffered result stale.
                        buf_valid_r <= 1'b0;
                        mc_drop     <= 1'b1;
                        state_r     <= IDLE;
                    end else if (wait_cnt_r == LAST_WAIT) begin
                        pipe_stall <= 1'b1;
                        state_r    <= FORCE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                FORCE: begin
                    buf_valid_r <= 1'b0;
                    pipe_stall  <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    buf_valid_r <= 1'b0;
                    pipe_stall  <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: it keeps a cycle-tagged scoreboard of expected register-file writes.
// It also checks mc_ready, pipe_stall and mc_drop at specific points in the sequence.
module tb_wb_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       pipe_we;
    logic [2:0] pipe_waddr;
    logic [7:0] pipe_wdata;
    logic       mc_valid;
    logic [2:0] mc_waddr;
    logic [7:0] mc_wdata;
    logic       mc_ready;
    logic       pipe_stall;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       mc_drop;

    typedef struct {
        int         due;
        logic [2:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   tests = 0;
    int   fails = 0;

    wb_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .mc_valid   (mc_valid),
        .mc_waddr   (mc_waddr),
        .mc_wdata   (mc_wdata),
        .mc_ready   (mc_ready),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .mc_drop    (mc_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        e.due = cycle + 1;
        e.a   = a;
        e.d   = d;
        sb.push_back(e);
    endtask

    // One clock: sample #1 after the edge, then settle the scoreboard for this cycle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (sb.size() > 0 && sb[0].due == cycle) begin
            e = sb.pop_front();
            chk("rf_we", 32'(rf_we), 32'd1);
            chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
            chk("rf_wdata", 32'(rf_wdata), 32'(e.d));
        end else begin
            chk("rf_we_quiet", 32'(rf_we), 32'd0);
        end
    endtask

    task automatic set_pipe(input logic we, input logic [2:0] a, input logic [7:0] d);
        pipe_we    = we;
        pipe_waddr = a;
        pipe_wdata = d;
    endtask

    task automatic set_mc(input logic v, input logic [2:0] a, input logic [7:0] d);
        mc_valid = v;
        mc_waddr = a;
        mc_wdata = d;
    endtask

    initial begin
        reset = 1'b1;
        set_pipe(1'b0, 3'd0, 8'h00);
        set_mc(1'b0, 3'd0, 8'h00);
        tick();
        tick();
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        chk("rst_drop", 32'(mc_drop), 32'd0);
        chk("rst_mc_ready", 32'(mc_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_mc_ready", 32'(mc_ready), 32'd1);

        // Pipeline-only write.
        set_pipe(1'b1, 3'd3, 8'h5A);
        push(3'd3, 8'h5A);
        tick();
        chk("pipe_stall_p", 32'(pipe_stall), 32'd0);
        set_pipe(1'b0, 3'd0, 8'h00);
        tick();

        // A multi-cycle result drains in an idle slot.
        set_mc(1'b1, 3'd2, 8'h11);
        tick();
        set_mc(1'b0, 3'd0, 8'h00);
        chk("held_mc_ready", 32'(mc_ready), 32'd0);
        push(3'd2, 8'h11);
        tick();
        chk("drain_mc_ready", 32'(mc_ready), 32'd1);

        // Starvation: continuous pipeline writes force one stall cycle.
        set_mc(1'b1, 3'd5, 8'h77);
        tick();
        set_mc(1'b0, 3'd0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            set_pipe(1'b1, (k % 2 == 0) ? 3'd1 : 3'd6, 8'h30 + 8'(k));
            push((k % 2 == 0) ? 3'd1 : 3'd6, 8'h30 + 8'(k));
            tick();
            chk("starve_stall", 32'(pipe_stall), (k == 3) ? 32'd1 : 32'd0);
            chk("starve_drop", 32'(mc_drop), 32'd0);
        end
        set_pipe(1'b1, 3'd1, 8'h40);
        push(3'd5, 8'h77);
        tick();
        chk("force_stall_end", 32'(pipe_stall), 32'd0);
        chk("force_mc_ready", 32'(mc_ready), 32'd1);
        set_pipe(1'b0, 3'd0, 8'h00);
        tick();

        // Conflict: a newer pipeline write to the same register discards the buffer.
        set_mc(1'b1, 3'd4, 8'h22);
        tick();
        set_mc(1'b0, 3'd0, 8'h00);
        set_pipe(1'b1, 3'd4, 8'h99);
        push(3'd4, 8'h99);
        tick();
        chk("conflict_drop", 32'(mc_drop), 32'd1);
        chk("conflict_mc_ready", 32'(mc_ready), 32'd1);
        set_pipe(1'b0, 3'd0, 8'h00);
        tick();
        chk("conflict_drop_once", 32'(mc_drop), 32'd0);
        tick();

        // Same-cycle accept and pipeline write in IDLE.
        set_mc(1'b1, 3'd3, 8'h44);
        set_pipe(1'b1, 3'd2, 8'h55);
        push(3'd2, 8'h55);
        tick();
        set_mc(1'b0, 3'd0, 8'h00);
        set_pipe(1'b0, 3'd0, 8'h00);
        push(3'd3, 8'h44);
        tick();

        // Write to r0 completes without a strobe.
        set_mc(1'b1, 3'd0, 8'hFF);
        tick();
        set_mc(1'b0, 3'd0, 8'h00);
        tick();
        chk("r0_mc_ready", 32'(mc_ready), 32'd1);
        tick();

        // Reset while a result is held discards it.
        set_mc(1'b1, 3'd7, 8'hAB);
        tick();
        set_mc(1'b0, 3'd0, 8'h00);
        reset = 1'b1;
        tick();
        chk("mid_rst_waddr", 32'(rf_waddr), 32'd0);
        chk("mid_rst_wdata", 32'(rf_wdata), 32'd0);
        chk("mid_rst_stall", 32'(pipe_stall), 32'd0);
        chk("mid_rst_drop", 32'(mc_drop), 32'd0);
        chk("mid_rst_mc_ready", 32'(mc_ready), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_drop", 32'(mc_drop), 32'd0);
        end
        chk("post_rst_mc_ready", 32'(mc_ready), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
